// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the memory arbiter:
//   arb_state_e  - arbiter FSM state encoding (ARB_IDLE, ARB_BUSY, ARB_DONE)
//   arb_owner_e  - bus owner selector (OWN_IF, OWN_MEM)
//   IF_BUS_SEL   - byte-lane mask driven for fetch reads (always a full word)
//   DEFAULT_WAIT_LIMIT - default bus_ack wait budget before a timeout abort
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

    localparam logic [3:0] IF_BUS_SEL        = 4'hF;
    localparam int         DEFAULT_WAIT_LIMIT = 64;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a single-port memory bus between the instruction-fetch port (IF)
// and the data port (MEM). MEM has fixed priority over IF. One transaction is
// in flight at a time; each one runs IDLE -> BUSY -> DONE -> IDLE.
//
// Handshake: a requester holds *_req high until it sees its *_ready pulse.
// The request (and its addr/data/sel) is sampled only on the grant edge; the
// bus fields are then frozen in registers for the whole BUSY phase, so the
// requester may change or drop its inputs afterwards. *_ready is a one-cycle
// pulse in the DONE cycle; *_rdata is valid from that cycle and holds until
// the next completion on the same port. On the bus side, bus_req stays high
// until the cycle bus_ack is sampled (or the wait budget runs out); bus_ack
// outside BUSY is ignored.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   if_req/if_addr      fetch read request
//   if_rdata/if_ready   fetch read data / completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_sel   data port request
//   mem_rdata/mem_ready data port read data / completion pulse
//   bus_req/bus_we/bus_addr/bus_wdata/bus_sel   shared memory bus request
//   bus_ack/bus_rdata   memory completion and read data
//   stall_from_if/stall_from_mem  stall requests to the pipeline
//   bus_err             one-cycle pulse with ready when a transaction timed out
//   dbg_state           current FSM state, for observation only
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    // Must be >= 1.
    parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,

    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,

    output logic        stall_from_if,
    output logic        stall_from_mem,
    output logic        bus_err,

    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    // Value the counter holds during the last BUSY cycle the budget allows.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e       state_q, state_d;
    arb_owner_e       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q,   bus_sel_d;

    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q,  if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        bus_err_q,   bus_err_d;

    logic [31:0] done_rdata;

    // Data returned to the owner on a successful completion; writes return 0.
    assign done_rdata = bus_we_q ? 32'h0 : bus_rdata;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (mem_req) begin
                    owner_d     = OWN_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_sel_d   = mem_sel;
                    cnt_d       = '0;
                    state_d     = ARB_BUSY;
                end else if (if_req) begin
                    owner_d     = OWN_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = 32'h0;
                    bus_sel_d   = IF_BUS_SEL;
                    cnt_d       = '0;
                    state_d     = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                // An ack in the last allowed cycle still counts as success.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = ARB_DONE;
                    if (owner_q == OWN_MEM) begin
                        mem_rdata_d = done_rdata;
                        mem_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = done_rdata;
                        if_ready_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Budget exhausted: abort, complete with zero data and flag it.
                    cnt_d     = cnt_q + CNT_ONE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ARB_DONE;
                    if (owner_q == OWN_MEM) begin
                        mem_rdata_d = 32'h0;
                        mem_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = 32'h0;
                        if_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ARB_DONE: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_sel_q   <= 4'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // A requester stops stalling only in its own completion cycle.
    assign stall_from_mem = mem_req & ~((state_q == ARB_DONE) && (owner_q == OWN_MEM));
    assign stall_from_if  = if_req  & ~((state_q == ARB_DONE) && (owner_q == OWN_IF));

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign bus_err   = bus_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Bench for mem_arbiter with WAIT_LIMIT = 4. Transactions are described at
// the request level (who asks, what, when the memory answers); expected bus
// fields, completion cycle, data and error are derived from the arbitration
// and timeout rules, and expected read data flows through exp_q.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int WL = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_from_if;
    logic        stall_from_mem;
    logic        bus_err;
    logic [1:0]  dbg_state;

    mem_arbiter #(.WAIT_LIMIT(WL)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_ready       (if_ready),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_sel        (mem_sel),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_sel        (bus_sel),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata),
        .stall_from_if  (stall_from_if),
        .stall_from_mem (stall_from_mem),
        .bus_err        (bus_err),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] m_if_rdata;
    logic [31:0] m_mem_rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Entry: at a negedge with the DUT idle. pat: 0 = IF only, 1 = MEM only,
    // 2 = both. k: BUSY cycle (1-based) in which bus_ack is given; k > WL
    // means the memory never answers. drop_at: BUSY cycle after which the
    // served requester drops its request (0 = never).
    task automatic run_txn(input int pat, input logic we, input logic [31:0] ia,
                           input logic [31:0] ma, input logic [31:0] wd,
                           input logic [3:0] sel, input int k,
                           input logic [31:0] ack_data, input int drop_at);
        logic        own_mem;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_sel;
        logic        timeout;
        logic [31:0] e_rd;
        int          n;

        if_req    = (pat != 1);
        mem_req   = (pat != 0);
        if_addr   = ia;
        mem_addr  = ma;
        mem_we    = we;
        mem_wdata = wd;
        mem_sel   = sel;

        own_mem = (pat != 0);
        e_addr  = own_mem ? ma : ia;
        e_we    = own_mem ? we : 1'b0;
        e_wdata = own_mem ? wd : 32'h0;
        e_sel   = own_mem ? sel : 4'hF;
        timeout = (k > WL);
        n       = timeout ? WL : k;
        e_rd    = timeout ? 32'h0 : ((own_mem && we) ? 32'h0 : ack_data);
        exp_q.push_back(e_rd);

        @(posedge clk);
        for (int cyc = 1; cyc <= n; cyc++) begin
            @(negedge clk);
            check_val("busy_bus_req", bus_req, 1'b1);
            check_val("busy_bus_addr", bus_addr, e_addr);
            check_val("busy_bus_we", bus_we, e_we);
            check_val("busy_bus_wdata", bus_wdata, e_wdata);
            check_val("busy_bus_sel", bus_sel, e_sel);
            check_val("busy_if_ready", if_ready, 1'b0);
            check_val("busy_mem_ready", mem_ready, 1'b0);
            check_val("busy_bus_err", bus_err, 1'b0);
            check_val("busy_stall_if", stall_from_if, if_req);
            check_val("busy_stall_mem", stall_from_mem, mem_req);
            if (drop_at == cyc) begin
                if (own_mem) mem_req = 1'b0;
                else if_req = 1'b0;
            end
            if_addr   = $urandom;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_sel   = 4'($urandom_range(0, 15));
            mem_we    = 1'($urandom_range(0, 1));
            bus_ack   = (cyc == k);
            bus_rdata = (cyc == k) ? ack_data : $urandom;
        end

        @(negedge clk);
        if (own_mem) m_mem_rdata = exp_q.pop_front();
        else m_if_rdata = exp_q.pop_front();
        check_val("done_bus_req", bus_req, 1'b0);
        check_val("done_if_ready", if_ready, !own_mem);
        check_val("done_mem_ready", mem_ready, own_mem);
        check_val("done_bus_err", bus_err, timeout);
        check_val("done_if_rdata", if_rdata, m_if_rdata);
        check_val("done_mem_rdata", mem_rdata, m_mem_rdata);
        check_val("done_stall_if", stall_from_if, if_req && own_mem);
        check_val("done_stall_mem", stall_from_mem, mem_req && !own_mem);
        // Stray acks outside BUSY must have no effect.
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;

        @(negedge clk);
        check_val("idle_state", dbg_state, ARB_IDLE);
        check_val("idle_bus_req", bus_req, 1'b0);
        check_val("idle_if_ready", if_ready, 1'b0);
        check_val("idle_mem_ready", mem_ready, 1'b0);
        check_val("idle_bus_err", bus_err, 1'b0);
        check_val("idle_if_rdata", if_rdata, m_if_rdata);
        check_val("idle_mem_rdata", mem_rdata, m_mem_rdata);
        check_val("idle_stall_if", stall_from_if, if_req);
        check_val("idle_stall_mem", stall_from_mem, mem_req);
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        if_req    = 1'b0;
        mem_req   = 1'b0;
    endtask

    task automatic reset_mid_busy();
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 32'h300;
        mem_wdata = 32'h0;
        mem_sel   = 4'hF;
        bus_ack   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_pre_bus_req", bus_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_val("rst_async_bus_req", bus_req, 1'b0);
        check_val("rst_async_state", dbg_state, ARB_IDLE);
        check_val("rst_async_stall_mem", stall_from_mem, 1'b1);
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF0000;
        mem_req   = 1'b0;
        m_if_rdata  = 32'h0;
        m_mem_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("rst_after_state", dbg_state, ARB_IDLE);
            check_val("rst_after_mem_ready", mem_ready, 1'b0);
            check_val("rst_after_if_ready", if_ready, 1'b0);
            check_val("rst_after_bus_req", bus_req, 1'b0);
            check_val("rst_after_mem_rdata", mem_rdata, m_mem_rdata);
        end
        bus_ack = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          pat;
        int          prev_pat;
        int          k;
        int          n;
        int          drop_at;
        logic [31:0] ia;

        n_tests     = 0;
        n_fail      = 0;
        m_if_rdata  = 32'h0;
        m_mem_rdata = 32'h0;
        rst       = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_sel   = 4'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;

        repeat (2) @(negedge clk);
        check_val("reset_bus_req", bus_req, 1'b0);
        check_val("reset_bus_we", bus_we, 1'b0);
        check_val("reset_bus_addr", bus_addr, 32'h0);
        check_val("reset_bus_wdata", bus_wdata, 32'h0);
        check_val("reset_bus_sel", bus_sel, 4'h0);
        check_val("reset_if_rdata", if_rdata, 32'h0);
        check_val("reset_mem_rdata", mem_rdata, 32'h0);
        check_val("reset_if_ready", if_ready, 1'b0);
        check_val("reset_mem_ready", mem_ready, 1'b0);
        check_val("reset_bus_err", bus_err, 1'b0);
        check_val("reset_state", dbg_state, ARB_IDLE);
        check_val("reset_stall_if", stall_from_if, 1'b1);
        check_val("reset_stall_mem", stall_from_mem, 1'b0);
        if_req = 1'b0;
        rst    = 1'b1;
        @(negedge clk);

        // Fetch read, ack in first BUSY cycle.
        run_txn(0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0);
        // Both request: MEM write first, then the waiting fetch.
        run_txn(2, 1'b1, 32'h104, 32'h200, 32'h12345678, 4'b0011, 2, 32'h55AA55AA, 0);
        run_txn(0, 1'b0, 32'h104, 32'h0, 32'h0, 4'h0, 1, 32'h0BADF00D, 0);
        // No ack at all: timeout abort.
        run_txn(1, 1'b0, 32'h0, 32'h400, 32'h0, 4'hF, WL + 1, 32'h0, 0);
        // Ack exactly on the last allowed cycle.
        run_txn(0, 1'b0, 32'h108, 32'h0, 32'h0, 4'h0, WL, 32'hA5A5A5A5, 0);
        // Requester drops mid-BUSY, ack three cycles later.
        run_txn(1, 1'b0, 32'h0, 32'h500, 32'h0, 4'hF, 4, 32'hCAFEF00D, 1);
        // Reset in the middle of a transaction.
        reset_mid_busy();

        prev_pat = 0;
        ia       = 32'h0;
        for (int t = 0; t < 40; t++) begin
            if (prev_pat == 2) begin
                pat = 0;
            end else begin
                pat = $urandom_range(0, 2);
                ia  = $urandom;
            end
            k       = $urandom_range(1, WL + 2);
            n       = (k > WL) ? WL : k;
            drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            run_txn(pat, 1'($urandom_range(0, 1)), ia, $urandom, $urandom,
                    4'($urandom_range(0, 15)), k, $urandom, drop_at);
            prev_pat = pat;
        end

        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
